// File: rtl/adat_rx_frame_buffer.sv
// ADAT receive frame buffer: detects deserialized frames, qualifies lock,
// queues locked frames and streams them out one channel word at a time.
module adat_rx_frame_buffer #(
    parameter int DEPTH_FRAMES   = 4,
    parameter int LOCK_FRAMES    = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_ready,
    input  logic                in_valid,
    input  logic [2:0]          in_user,
    input  logic [7:0][23:0]    in_audio,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [23:0]  out_data,
    output logic [2:0]          out_chan,
    output logic                out_first,
    output logic [2:0]          out_user,
    output logic                locked,
    output logic                overflow,
    output logic [7:0]          err_count,
    input  logic                clr_status
);

    localparam int AW = $clog2(DEPTH_FRAMES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic [2:0]       user;
        logic [7:0][23:0] audio;
    } frame_t;

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    state_t        state, state_n;
    logic [3:0]    good, good_n;
    logic          prev_ready, ev, tmo, err_inc, flush;
    logic [TW-1:0] tmo_cnt;

    frame_t        mem [DEPTH_FRAMES];
    frame_t        cap, head, nxt;
    logic          cap_push;
    logic [AW:0]   wr_ptr, rd_ptr, rd_nxt, fill;
    logic          xfer, pop, full, more, start, accept, drop;
    logic [2:0]    chan_n;

    assign ev     = in_ready && !prev_ready;
    assign tmo    = (state != UNLOCKED) && !ev && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign rd_nxt = rd_ptr + 1'b1;
    assign fill   = wr_ptr - rd_ptr;
    assign full   = (fill == (AW+1)'(DEPTH_FRAMES));
    assign head   = mem[rd_ptr[AW-1:0]];
    assign nxt    = mem[rd_nxt[AW-1:0]];
    assign xfer   = out_valid && out_ready;
    assign pop    = xfer && (out_chan == 3'd7);
    assign chan_n = out_chan + 3'd1;
    assign start  = !out_valid && (fill != '0);
    assign flush  = (state != UNLOCKED) && (state_n == UNLOCKED);
    assign more   = (rd_nxt != wr_ptr) && !flush;
    // the channel-7 pop on this edge frees a slot for the arriving frame
    assign accept = ev && in_valid && (state == LOCKED) && (!full || pop);
    assign drop   = ev && in_valid && (state == LOCKED) && full && !pop;

    always_comb begin
        state_n = state;
        good_n  = good;
        err_inc = 1'b0;
        case (state)
            UNLOCKED: begin
                if (ev && in_valid) begin
                    good_n = 4'd1;
                    if (LOCK_FRAMES == 1) state_n = LOCKED;
                    else                  state_n = ACQUIRE;
                end else if (ev) begin
                    err_inc = 1'b1;
                end
            end
            ACQUIRE: begin
                if (ev && in_valid) begin
                    good_n = good + 4'd1;
                    if (good_n == 4'(LOCK_FRAMES)) state_n = LOCKED;
                end else if (ev || tmo) begin
                    state_n = UNLOCKED;
                    err_inc = 1'b1;
                end
            end
            LOCKED: begin
                if ((ev && !in_valid) || tmo) begin
                    state_n = UNLOCKED;
                    err_inc = 1'b1;
                end
            end
            default: state_n = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cap_push) mem[wr_ptr[AW-1:0]] <= cap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= UNLOCKED;
            good       <= '0;
            prev_ready <= 1'b1;
            tmo_cnt    <= '0;
            locked     <= 1'b0;
            overflow   <= 1'b0;
            err_count  <= '0;
            cap        <= '0;
            cap_push   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            out_first  <= 1'b0;
            out_user   <= '0;
        end else begin
            state      <= state_n;
            good       <= good_n;
            prev_ready <= in_ready;
            locked     <= (state_n == LOCKED);

            if (ev)                                     tmo_cnt <= '0;
            else if (tmo_cnt != TW'(TIMEOUT_CYCLES))    tmo_cnt <= tmo_cnt + 1'b1;

            if (ev) cap <= {in_user, in_audio};
            cap_push <= accept;

            if (clr_status) overflow <= 1'b0;
            else if (drop)  overflow <= 1'b1;

            if (clr_status)                         err_count <= '0;
            else if (err_inc && err_count != 8'hff) err_count <= err_count + 8'd1;

            // on lock loss keep only the frame already being presented
            if (flush)         wr_ptr <= (out_valid || start) ? rd_nxt : rd_ptr;
            else if (cap_push) wr_ptr <= wr_ptr + 1'b1;

            if (start) begin
                out_valid <= 1'b1;
                out_data  <= head.audio[0];
                out_chan  <= 3'd0;
                out_first <= 1'b1;
                out_user  <= head.user;
            end else if (xfer && !pop) begin
                out_data  <= head.audio[chan_n];
                out_chan  <= chan_n;
                out_first <= 1'b0;
            end else if (pop) begin
                rd_ptr <= rd_nxt;
                if (more) begin
                    out_data  <= nxt.audio[0];
                    out_chan  <= 3'd0;
                    out_first <= 1'b1;
                    out_user  <= nxt.user;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_adat_rx_frame_buffer.sv
// Directed bench for adat_rx_frame_buffer: lock acquisition, queueing,
// overflow, lock loss, timeout, stall stability and reset behaviour.
module tb_adat_rx_frame_buffer;

    logic               clk = 1'b0, rst = 1'b1;
    logic               in_ready = 1'b0, in_valid = 1'b0, clr_status = 1'b0;
    logic [2:0]         in_user = '0;
    logic [7:0][23:0]   in_audio = '0;
    logic               out_ready, rdy_drv = 1'b1, rnd_en = 1'b0, rnd_bit = 1'b0;
    logic               out_valid, out_first, locked, overflow;
    logic signed [23:0] out_data;
    logic [2:0]         out_chan, out_user;
    logic [7:0]         err_count;

    typedef struct packed {
        logic        first;
        logic [2:0]  user;
        logic [2:0]  chan;
        logic [23:0] data;
    } word_t;

    word_t wq[$];
    word_t prev_w, cur_w;
    logic  stall_prev = 1'b0;
    logic  lat0, lat1, lat2, lk0;
    int    nvec = 0, nerr = 0;

    assign out_ready = rnd_en ? rnd_bit : rdy_drv;

    adat_rx_frame_buffer dut (
        .clk(clk), .rst(rst), .in_ready(in_ready), .in_valid(in_valid),
        .in_user(in_user), .in_audio(in_audio), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
        .out_first(out_first), .out_user(out_user), .locked(locked),
        .overflow(overflow), .err_count(err_count), .clr_status(clr_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] samp(input int c, input int f);
        return 24'((c << 16) + f);
    endfunction

    function automatic word_t exp_w(input int c, input int f);
        word_t w;
        w.first = (c == 0);
        w.user  = 3'(f);
        w.chan  = 3'(c);
        w.data  = samp(c, f);
        return w;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setf(input logic v, input int f);
        in_valid = v;
        in_user  = 3'(f);
        for (int c = 0; c < 8; c++) in_audio[c] = samp(c, f);
    endtask

    // one in_ready pulse four cycles wide, then gap idle cycles
    task automatic frame(input logic v, input int f, input int gap);
        setf(v, f);
        in_ready = 1'b1;
        cyc(1); lat0 = out_valid; lk0 = locked;
        cyc(1); lat1 = out_valid;
        cyc(1); lat2 = out_valid;
        cyc(1);
        in_ready = 1'b0;
        cyc(gap);
    endtask

    task automatic chk_frames(input int base, input int f);
        for (int c = 0; c < 8; c++)
            chk("word", 32'(wq[base + c]), 32'(exp_w(c, f)));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    // transfer recorder and stall-stability monitor
    initial begin
        forever begin
            @(negedge clk);
            cur_w = {out_first, out_user, out_chan, out_data};
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) chk("stall_hold", {out_valid, cur_w}, {1'b1, prev_w});
                if (out_valid && out_ready) wq.push_back(cur_w);
                stall_prev = out_valid && !out_ready;
                prev_w     = cur_w;
            end
        end
    end

    initial begin
        cyc(3);
        chk("rst0_out", {28'd0, out_valid, out_first, locked, overflow}, 32'd0);
        chk("rst0_word", {1'b0, out_user, out_chan, 1'b0, out_data}, 32'd0);
        chk("rst0_err", 32'(err_count), 32'd0);
        rst = 1'b0;
        cyc(1);

        // acquisition, then two locked frames streamed with ready high
        for (int f = 1; f <= 6; f++) begin
            frame(1'b1, f, 2044);
            if (f == 3) chk("lock3", 32'(locked), 32'd0);
            if (f == 4) chk("lock4_edge", 32'(lk0), 32'd1);
            if (f == 5) chk("latency", {29'd0, lat0, lat1, lat2}, 32'b001);
        end
        chk("t1_count", 32'(wq.size()), 32'd16);
        chk_frames(0, 5);
        chk_frames(8, 6);

        // FIFO fills with ready low; two frames dropped; burst drains
        wq.delete();
        rdy_drv = 1'b0;
        for (int f = 11; f <= 16; f++) begin
            frame(1'b1, f, 60);
            if (f == 14) chk("ovf_pre", 32'(overflow), 32'd0);
            if (f == 15) chk("ovf_set", 32'(overflow), 32'd1);
        end
        rdy_drv = 1'b1;
        cyc(31);
        chk("burst_busy", 32'(out_valid), 32'd1);
        cyc(1);
        chk("burst_done", 32'(out_valid), 32'd0);
        chk("t2_count", 32'(wq.size()), 32'd32);
        for (int i = 0; i < 4; i++) chk_frames(i * 8, 11 + i);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // invalid frame mid-stream: current frame completes, rest discarded
        wq.delete();
        rdy_drv = 1'b0;
        frame(1'b1, 21, 60);
        frame(1'b1, 22, 60);
        rdy_drv = 1'b1;
        cyc(3);
        rdy_drv = 1'b0;
        chk("t3_chan", 32'(out_chan), 32'd3);
        frame(1'b0, 23, 20);
        chk("t3_unlock", 32'(locked), 32'd0);
        chk("t3_err", 32'(err_count), 32'd1);
        rdy_drv = 1'b1;
        cyc(20);
        chk("t3_count", 32'(wq.size()), 32'd8);
        chk_frames(0, 21);
        chk("t3_idle", 32'(out_valid), 32'd0);

        // relock, stream under random stalls, then time out
        wq.delete();
        for (int f = 31; f <= 34; f++) frame(1'b1, f, 60);
        chk("t4_relock", 32'(locked), 32'd1);
        rnd_en = 1'b1;
        frame(1'b1, 35, 60);
        setf(1'b1, 36);
        in_ready = 1'b1;
        cyc(1);
        cyc(3);
        in_ready = 1'b0;
        cyc(300);
        rnd_en = 1'b0;
        cyc(3792);
        chk("t4_pre", 32'(locked), 32'd1);
        chk("t4_err_pre", 32'(err_count), 32'd1);
        cyc(1);
        chk("t4_drop", 32'(locked), 32'd0);
        chk("t4_err", 32'(err_count), 32'd2);
        chk("t4_count", 32'(wq.size()), 32'd16);
        chk_frames(0, 35);
        chk_frames(8, 36);
        cyc(900);
        chk("t4_once", 32'(err_count), 32'd2);

        // reset mid-stream with in_ready held high across release
        for (int f = 41; f <= 44; f++) frame(1'b1, f, 60);
        rdy_drv = 1'b0;
        frame(1'b1, 45, 60);
        chk("t5_stream", 32'(out_valid), 32'd1);
        setf(1'b1, 46);
        in_ready = 1'b1;
        cyc(1);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        in_valid = 1'b0;
        cyc(1);
        chk("rst_out", {28'd0, out_valid, out_first, locked, overflow}, 32'd0);
        chk("rst_word", {1'b0, out_user, out_chan, 1'b0, out_data}, 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        rdy_drv = 1'b1;
        cyc(8);
        chk("no_cap_err", 32'(err_count), 32'd0);
        chk("no_cap_valid", 32'(out_valid), 32'd0);
        in_ready = 1'b0;
        cyc(2);
        clr_status = 1'b1;
        in_ready   = 1'b1;
        cyc(1);
        clr_status = 1'b0;
        chk("clr_wins", 32'(err_count), 32'd0);
        cyc(2);
        in_ready = 1'b0;
        cyc(2);
        in_ready = 1'b1;
        cyc(1);
        chk("err_after", 32'(err_count), 32'd1);
        in_ready = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
